// File: rtl/magphase_to_complex.sv
// Joins magnitude/phase AXI streams and rotates each magnitude by its phase with a pipelined CORDIC.
// Latency ITERATIONS+2 edges incl. the accepting edge; the whole pipe stalls only while o_tvalid && !o_tready.
module magphase_to_complex #(
  parameter int ITERATIONS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] mag_tdata,
  input  logic        mag_tlast,
  input  logic        mag_tvalid,
  output logic        mag_tready,
  input  logic [31:0] phase_tdata,
  input  logic        phase_tlast,
  input  logic        phase_tvalid,
  output logic        phase_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] tlast_err_cnt
);

  localparam int N = ITERATIONS;
  localparam logic signed [15:0] PH_MAX  = 16'sd25736;
  localparam logic signed [19:0] HALF_PI = 20'sd102944;
  localparam logic [29:0]        K_INV   = 30'd19899;

  function automatic logic signed [19:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 20'sd51472;
      1:       atan_lut = 20'sd30385;
      2:       atan_lut = 20'sd16055;
      3:       atan_lut = 20'sd8150;
      4:       atan_lut = 20'sd4091;
      5:       atan_lut = 20'sd2047;
      6:       atan_lut = 20'sd1024;
      7:       atan_lut = 20'sd512;
      8:       atan_lut = 20'sd256;
      9:       atan_lut = 20'sd128;
      10:      atan_lut = 20'sd64;
      11:      atan_lut = 20'sd32;
      12:      atan_lut = 20'sd16;
      13:      atan_lut = 20'sd8;
      14:      atan_lut = 20'sd4;
      15:      atan_lut = 20'sd2;
      default: atan_lut = 20'sd0;
    endcase
  endfunction

  // Q2.17 -> Q1.15 with round half-up and saturation.
  function automatic logic [15:0] sat16(input logic signed [19:0] v);
    logic signed [20:0] s;
    s = ($signed({v[19], v}) + 21'sd2) >>> 2;
    if (s > 21'sd32767)       sat16 = 16'h7FFF;
    else if (s < -21'sd32768) sat16 = 16'h8000;
    else                      sat16 = s[15:0];
  endfunction

  logic               rst;
  logic               en;
  logic               accept;
  logic signed [15:0] ph_s;
  logic signed [15:0] ph_c;
  logic [29:0]        prod;
  logic signed [19:0] x_pre;
  logic signed [19:0] z_pre;
  logic unused_ok;

  logic signed [19:0] x_d [0:N];
  logic signed [19:0] y_d [0:N];
  logic signed [19:0] z_d [0:N-1];
  logic               vld_d [0:N];
  logic               last_d [0:N];
  logic signed [19:0] x_q [0:N];
  logic signed [19:0] y_q [0:N];
  logic signed [19:0] z_q [0:N-1];
  logic               vld_q [0:N];
  logic               last_q [0:N];

  logic [31:0] out_dat_q;
  logic        out_vld_q;
  logic        out_last_q;
  logic [15:0] cnt_q, cnt_d;

  assign rst          = reset | clear;
  assign en           = o_tready | ~out_vld_q;
  assign mag_tready   = en & phase_tvalid;
  assign phase_tready = en & mag_tvalid;
  assign accept       = en & mag_tvalid & phase_tvalid;
  assign unused_ok    = ^{mag_tdata[15:0], phase_tdata[15:0]};

  always_comb begin
    ph_s = $signed(phase_tdata[31:16]);
    ph_c = ph_s;
    if (ph_s > PH_MAX)       ph_c = PH_MAX;
    else if (ph_s < -PH_MAX) ph_c = -PH_MAX;
    prod  = mag_tdata[31] ? 30'd0 : {15'd0, mag_tdata[30:16]} * K_INV;
    x_pre = 20'((31'(prod) + 31'd4096) >> 13);
    z_pre = $signed({ph_c[15], ph_c, 3'b000});

    // Pre-rotate by +/-pi/2 so the remaining angle is inside CORDIC convergence range.
    x_d[0]    = x_pre;
    y_d[0]    = '0;
    z_d[0]    = z_pre;
    vld_d[0]  = accept;
    last_d[0] = mag_tlast;
    if (z_pre > HALF_PI) begin
      x_d[0] = '0;
      y_d[0] = x_pre;
      z_d[0] = z_pre - HALF_PI;
    end else if (z_pre < -HALF_PI) begin
      x_d[0] = '0;
      y_d[0] = -x_pre;
      z_d[0] = z_pre + HALF_PI;
    end

    for (int k = 0; k < N; k++) begin
      vld_d[k+1]  = vld_q[k];
      last_d[k+1] = last_q[k];
      if (!z_q[k][19]) begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        y_d[k+1] = y_q[k] + (x_q[k] >>> k);
        if (k < N - 1) z_d[k+1] = z_q[k] - atan_lut(k);
      end else begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        y_d[k+1] = y_q[k] - (x_q[k] >>> k);
        if (k < N - 1) z_d[k+1] = z_q[k] + atan_lut(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k <= N; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      for (int k = 0; k < N; k++) z_q[k] <= z_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= N; k++) begin
        vld_q[k]  <= 1'b0;
        last_q[k] <= 1'b0;
      end
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else if (en) begin
      for (int k = 0; k <= N; k++) begin
        vld_q[k]  <= vld_d[k];
        last_q[k] <= last_d[k];
      end
      out_vld_q  <= vld_q[N];
      out_last_q <= vld_q[N] & last_q[N];
      if (vld_q[N]) out_dat_q <= {sat16(x_q[N]), sat16(y_q[N])};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (mag_tlast != phase_tlast) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_tdata       = out_dat_q;
  assign o_tlast       = out_last_q;
  assign o_tvalid      = out_vld_q;
  assign tlast_err_cnt = cnt_q;

endmodule

// File: tb/tb_magphase_to_complex.sv
// Scoreboard bench: driver pushes ideal polar->cartesian results, monitor pops on each output handshake.
module tb_magphase_to_complex;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] mag_tdata, phase_tdata, o_tdata;
  logic        mag_tlast, mag_tvalid, mag_tready;
  logic        phase_tlast, phase_tvalid, phase_tready;
  logic        o_tlast, o_tvalid, o_tready;
  logic [15:0] tlast_err_cnt;

  always #5 clk = ~clk;

  magphase_to_complex #(.ITERATIONS(14)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .mag_tdata(mag_tdata), .mag_tlast(mag_tlast), .mag_tvalid(mag_tvalid), .mag_tready(mag_tready),
    .phase_tdata(phase_tdata), .phase_tlast(phase_tlast), .phase_tvalid(phase_tvalid),
    .phase_tready(phase_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .tlast_err_cnt(tlast_err_cnt)
  );

  typedef struct { int i; int q; bit last; int tol; } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;
  bit   rand_rdy = 0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int rndi(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Ideal model: mag*cos/sin(phase) in real arithmetic.
  task automatic push_exp(input logic signed [15:0] m, input logic signed [15:0] p,
                          input bit ml, input bit pl, input int tol);
    exp_t e;
    int   mi, pi;
    real  r, a;
    mi = (m < 0) ? 0 : int'(m);
    pi = clampi(int'(p), -25736, 25736);
    r  = mi / 32768.0;
    a  = pi / 8192.0;
    e.i    = clampi(rndi(r * $cos(a) * 32768.0), -32768, 32767);
    e.q    = clampi(rndi(r * $sin(a) * 32768.0), -32768, 32767);
    e.last = ml;
    e.tol  = tol;
    exp_q.push_back(e);
    if (ml != pl && exp_err < 65535) exp_err++;
  endtask

  task automatic send(input logic signed [15:0] m, input logic signed [15:0] p,
                      input bit ml, input bit pl, input int tol, input bit indep);
    bit mv = 0, pv = 0, done = 0, am, ap;
    int cyc = 0;
    mag_tdata   = {m, 16'($urandom)};
    phase_tdata = {p, 16'($urandom)};
    mag_tlast   = ml;
    phase_tlast = pl;
    while (!done) begin
      if (indep) begin
        mv = mv | ($urandom_range(0, 2) == 0);
        pv = pv | ($urandom_range(0, 2) == 0);
      end else begin
        mv = 1;
        pv = 1;
      end
      mag_tvalid   = mv;
      phase_tvalid = pv;
      @(negedge clk);
      am = mag_tvalid && mag_tready;
      ap = phase_tvalid && phase_tready;
      check("join", am == ap, int'(am), int'(ap));
      if (am && ap) begin
        push_exp(m, p, ml, pl, tol);
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 500) begin
        check("accept_timeout", 0, cyc, 500);
        done = 1;
      end
    end
    mag_tvalid   = 0;
    phase_tvalid = 0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() > 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("drain", exp_q.size() == 0, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1;
    exp_q.delete();
    @(posedge clk); #1;
    reset   = 0;
    exp_err = 0;
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, readys during stall.
  initial begin
    exp_t        e;
    int          ai, aq;
    logic [31:0] prev_d = '0;
    bit          prev_l = 0, prev_stall = 0, prev_rst = 0;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rst) begin
        check("stall_vld", o_tvalid == 1'b1, int'(o_tvalid), 1);
        check("stall_dat", o_tdata == prev_d, int'(o_tdata), int'(prev_d));
        check("stall_last", o_tlast == prev_l, int'(o_tlast), int'(prev_l));
      end
      if (o_tvalid && !o_tready)
        check("stall_rdy", !mag_tready && !phase_tready, int'({mag_tready, phase_tready}), 0);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 0, int'(o_tdata), 0);
        end else begin
          e  = exp_q.pop_front();
          ai = $signed(o_tdata[31:16]);
          aq = $signed(o_tdata[15:0]);
          check("out_i", (ai - e.i <= e.tol) && (e.i - ai <= e.tol), ai, e.i);
          check("out_q", (aq - e.q <= e.tol) && (e.q - aq <= e.tol), aq, e.q);
          check("out_last", o_tlast == e.last, int'(o_tlast), int'(e.last));
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_d     = o_tdata;
      prev_l     = o_tlast;
      prev_rst   = reset || clear;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) o_tready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic signed [15:0] m, p;
    bit ml, pl;
    reset = 1; clear = 0; o_tready = 1;
    mag_tdata = '0; phase_tdata = '0;
    mag_tlast = 0; phase_tlast = 0; mag_tvalid = 0; phase_tvalid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    @(negedge clk);
    check("rst_vld", o_tvalid == 1'b0, int'(o_tvalid), 0);
    check("rst_dat", o_tdata == 32'd0, int'(o_tdata), 0);
    check("rst_last", o_tlast == 1'b0, int'(o_tlast), 0);
    check("rst_cnt", tlast_err_cnt == 16'd0, int'(tlast_err_cnt), 0);
    // Empty output: pipe runs even with o_tready low; a one-sided valid only raises the other ready.
    o_tready = 0; phase_tvalid = 1;
    #1;
    check("bubble_mag_rdy", mag_tready == 1'b1, int'(mag_tready), 1);
    check("one_side_phase_rdy", phase_tready == 1'b0, int'(phase_tready), 0);
    phase_tvalid = 0; o_tready = 1;
    @(posedge clk); #1;

    // Latency, counting the accepting edge as edge 1.
    send(16'sd32767, 16'sd0, 0, 0, 4, 0);
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (o_tvalid) break;
      @(posedge clk);
      n++;
    end
    check("latency", n == 16, n, 16);
    drain();

    send(16'sd32767, 16'sd12868, 0, 0, 4, 0);
    send(16'sd32767, -16'sd25736, 0, 0, 4, 0);
    send(16'sd16384, 16'sd6434, 0, 0, 4, 0);
    send(16'sd20000, 16'sd30000, 0, 0, 6, 0);
    send(16'sd20000, -16'sd32768, 0, 0, 6, 0);
    send(-16'sd5000, 16'sd1000, 0, 0, 4, 0);
    drain();

    for (int k = 0; k < 4096; k++) begin
      p = 16'(-25736 + (51472 * k) / 4095);
      send(16'sd30000, p, 0, 0, 6, 0);
    end
    drain();

    // Stalled output: hold checks run in the monitor, readys must be low.
    o_tready = 0;
    for (int k = 0; k < 3; k++) send(16'(1000 * (k + 1)), 16'(3000 * k), 0, 0, 4, 0);
    repeat (25) @(posedge clk);
    #1;
    mag_tvalid = 1; phase_tvalid = 1;
    #1;
    check("stall_vld_hi", o_tvalid == 1'b1, int'(o_tvalid), 1);
    check("stall_join_rdy", !mag_tready && !phase_tready, int'({mag_tready, phase_tready}), 0);
    mag_tvalid = 0; phase_tvalid = 0;
    o_tready = 1;
    drain();

    rand_rdy = 1;
    for (int b = 0; b < 2000; b++) begin
      m  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32767));
      p  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 51472) - 25736);
      ml = ($urandom_range(0, 3) == 0);
      pl = ($urandom_range(0, 7) == 0) ? !ml : ml;
      send(m, p, ml, pl, 7, 1);
    end
    rand_rdy = 0;
    @(posedge clk); #1 o_tready = 1;
    drain();
    check("rand_err_cnt", int'(tlast_err_cnt) == exp_err, int'(tlast_err_cnt), exp_err);

    pulse_reset();
    for (int b = 1; b <= 8; b++)
      send(16'($urandom_range(0, 32767)), 16'($urandom_range(0, 51472) - 25736),
           (b == 3 || b == 7), (b == 4 || b == 7), 7, 0);
    drain();
    check("mismatch_cnt", tlast_err_cnt == 16'd2, int'(tlast_err_cnt), 2);

    // Reset with 10 beats in flight.
    for (int b = 0; b < 10; b++)
      send(16'($urandom_range(0, 32767)), 16'($urandom_range(0, 51472) - 25736), b == 4, 0, 7, 0);
    @(negedge clk);
    check("inflight_cnt", int'(tlast_err_cnt) == exp_err, int'(tlast_err_cnt), exp_err);
    pulse_reset();
    @(negedge clk);
    check("rst_mid_vld", o_tvalid == 1'b0, int'(o_tvalid), 0);
    check("rst_mid_cnt", tlast_err_cnt == 16'd0, int'(tlast_err_cnt), 0);
    @(posedge clk); #1;
    send(16'sd12000, -16'sd9000, 0, 0, 4, 0);
    drain();

    // Clear during a mismatched beat: the beat is dropped and the counter stays 0.
    @(posedge clk); #1;
    clear = 1; mag_tvalid = 1; phase_tvalid = 1;
    mag_tdata = {16'sd9000, 16'h0}; phase_tdata = {16'sd500, 16'h0};
    mag_tlast = 1; phase_tlast = 0;
    @(posedge clk); #1;
    clear = 0; mag_tvalid = 0; phase_tvalid = 0;
    @(negedge clk);
    check("clear_wins_cnt", tlast_err_cnt == 16'd0, int'(tlast_err_cnt), 0);
    repeat (20) @(posedge clk);
    #1;
    send(16'sd25000, 16'sd20000, 1, 1, 4, 0);
    drain();
    check("final_cnt", int'(tlast_err_cnt) == exp_err, int'(tlast_err_cnt), exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
